// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and sizing helpers for the wide add sequencer.
// Holds the controller state encoding and the slice-index width rule.
// Optional feature macro used by the block: WIDE_ADD_SUB_EN (subtract select).
package wide_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WORDS = 4;

  // Slice index needs at least one bit even when a single slice is used.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int IDX_W = idx_width(DEF_WORDS);

endpackage

// File: rtl/wide_add_sequencer_cla_slice.sv
// N-bit carry-lookahead adder slice with full internal carry vector.
// Latency: purely combinational.
// Backpressure: none; the controller decides when the result is captured.
module cla_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic [N:0]   c
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flattened sum of products of generate/propagate terms.
  always_comb begin
    logic w_term;
    logic w_acc;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      w_acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k <= i; k++) begin
          w_term = w_term & w_p[k];
        end
        w_acc = w_acc | w_term;
      end
      w_term = cin;
      for (int k = 0; k <= i; k++) begin
        w_term = w_term & w_p[k];
      end
      c[i+1] = w_acc | w_term;
    end
  end

  assign s = w_p ^ c[N-1:0];

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds two N*WORDS-bit operands by reusing one N-bit CLA slice, LSB slice first.
// Latency: WORDS cycles from accept edge to out_valid; accepts spaced >= WORDS+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Macro: WIDE_ADD_SUB_EN.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
`ifdef WIDE_ADD_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic            r_cout;
  logic            r_ovf;

  logic [N-1:0]    w_sa;
  logic [N-1:0]    w_sb;
  logic [N-1:0]    w_s;
  logic [N:0]      w_c;
  logic            w_last;
  logic            w_accept;
  logic            w_b_invert;
  logic            w_cin0;
  logic            w_unused_c;

`ifdef WIDE_ADD_SUB_EN
  // Subtraction is a + ~b + 1: invert b at capture and seed the carry.
  assign w_b_invert = sub;
  assign w_cin0     = sub;
`else
  assign w_b_invert = 1'b0;
  assign w_cin0     = 1'b0;
`endif

  assign w_sa       = r_a[int'(r_idx)*N +: N];
  assign w_sb       = r_b[int'(r_idx)*N +: N];
  assign w_last     = (r_idx == IW'(WORDS - 1));
  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_unused_c = ^w_c;

  cla_slice #(.N(N)) u_slice (
    .a   (w_sa),
    .b   (w_sb),
    .cin (r_carry),
    .s   (w_s),
    .c   (w_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: one RUN cycle per slice, DONE holds until consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then fold one slice per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_invert ? ~b : b;
      r_carry <= w_cin0;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[int'(r_idx)*N +: N] <= w_s;
      r_carry                   <= w_c[N];
      r_idx                     <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c[N];
        r_ovf  <= w_c[N] ^ w_c[N-1];
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
